pixel_readout_capture: RTL

Sink-side counterpart of the exposure/readout controller: watches the active-low row enables NRE_1/NRE_2 and the ADC convert strobe it drives, and captures one ADC sample per conversion, tagged with the row that was enabled. Samples go into a small FIFO and leave on a valid/ready stream toward the image store. The block also reports frame completion (row 0 then row 1 captured) and flags protocol violations. erase, from the same controller, flushes the block at the start of each new exposure.

---
 rtl/pixel_readout_capture_if.sv | 9 +
 rtl/pixel_readout_capture.sv | 98 +++++++++
 2 files changed

// File: rtl/pixel_readout_capture_if.sv
// pixel_readout_capture_if: sample stream toward the image store (head data, row tag, valid/ready).
interface pixel_readout_capture_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] out_data;
  logic              out_row;
  logic              out_valid;
  logic              out_ready;
  modport master(output out_data, out_row, out_valid, input out_ready);
  modport slave(input out_data, out_row, out_valid, output out_ready);
endinterface

// File: rtl/pixel_readout_capture.sv
// pixel_readout_capture: captures one row-tagged ADC sample per conversion into a FIFO,
// tracks frame completion and flags protocol violations.
module pixel_readout_capture #(
  parameter int DATA_W      = 8,
  parameter int CONV_CYCLES = 2,
  parameter int DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   NRE_1,
  input  logic                   NRE_2,
  input  logic                   ADC,
  input  logic                   erase,
  input  logic [DATA_W-1:0]      adc_data,
  pixel_readout_capture_if.master out_s,
  output logic                   frame_done,
  output logic                   overflow,
  output logic                   protocol_err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, CONV} state_t;
  state_t            r_state, w_state_nx;
  logic [3:0]        r_cnt, w_cnt_nx;
  logic              r_row, w_row_nx;
  logic              r_adc_q, r_row0_seen;
  logic [DATA_W:0]   r_mem [DEPTH];
  logic [AW:0]       r_wp, r_rp;
  logic              w_rise, w_legal, w_sample, w_err;
  logic              w_empty, w_full, w_pop, w_wr, w_ovf;
  assign w_rise  = ADC & ~r_adc_q;
  assign w_legal = NRE_1 ^ NRE_2;
  assign w_empty = r_wp == r_rp;
  assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_pop   = ~w_empty & out_s.out_ready;
  assign w_wr    = w_sample & (~w_full | w_pop);
  assign w_ovf   = w_sample & w_full & ~w_pop;
  assign out_s.out_valid = ~w_empty;
  assign out_s.out_data  = r_mem[r_rp[AW-1:0]][DATA_W-1:0];
  assign out_s.out_row   = r_mem[r_rp[AW-1:0]][DATA_W];
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_row_nx   = r_row;
    w_sample   = 1'b0;
    w_err      = 1'b0;
    if (r_state == IDLE) begin
      if (w_rise && w_legal) begin
        w_state_nx = CONV;
        w_cnt_nx   = 4'(CONV_CYCLES - 1);
        w_row_nx   = NRE_1;
      end
      w_err = w_rise & ~w_legal;
    end else begin
      w_err      = w_rise;
      w_sample   = r_cnt == 4'd0;
      w_state_nx = w_sample ? IDLE : CONV;
      w_cnt_nx   = w_sample ? r_cnt : r_cnt - 4'd1;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_row        <= 1'b0;
      r_adc_q      <= 1'b0;
      r_row0_seen  <= 1'b0;
      r_wp         <= '0;
      r_rp         <= '0;
      frame_done   <= 1'b0;
      overflow     <= 1'b0;
      protocol_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_adc_q <= ADC;
      if (erase) begin
        r_state      <= IDLE;
        r_wp         <= '0;
        r_rp         <= '0;
        r_row0_seen  <= 1'b0;
        frame_done   <= 1'b0;
        overflow     <= 1'b0;
        protocol_err <= 1'b0;
      end else begin
        r_state    <= w_state_nx;
        r_cnt      <= w_cnt_nx;
        r_row      <= w_row_nx;
        if (w_wr) r_mem[r_wp[AW-1:0]] <= {r_row, adc_data};
        r_wp       <= r_wp + {{AW{1'b0}}, w_wr};
        r_rp       <= r_rp + {{AW{1'b0}}, w_pop};
        // Frame tracking follows every sample, including ones dropped on overflow
        frame_done <= w_sample & r_row & r_row0_seen;
        if (w_sample) r_row0_seen <= ~r_row;
        if (w_ovf) overflow <= 1'b1;
        if (w_err || (w_sample && r_row && !r_row0_seen)) protocol_err <= 1'b1;
      end
    end
  end
endmodule
